// File: rtl/morse_pkg.sv
// morse_pkg: shared constants and FSM state encoding for the morse scheduler
package morse_pkg;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam int UNIT_CYCLES = 5_000_000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head read and synchronous flush
module sync_fifo #(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 6
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_BITS:0]   cnt_q;
    logic                 wr, rd;

    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (ADDR_BITS + 1)'(DEPTH);
    assign wr      = wr_en_i && !full_o && !clear_i;
    assign rd      = rd_en_i && !empty_o && !clear_i;
    assign head_o  = mem_q[rd_ptr_q];

    // pointer and occupancy bookkeeping; flush and reset both empty the queue
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + (ADDR_BITS + 1)'(wr) - (ADDR_BITS + 1)'(rd);
        end
    end

    // storage array, no reset needed since count gates visibility
    always_ff @(posedge clk_i) begin
        if (wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/morse_scheduler.sv
// morse_scheduler: queues received bytes and paces them into the morse generator
// Optional generator-done watchdog enabled by defining MORSE_SCHED_TIMEOUT_EN.
module morse_scheduler
    import morse_pkg::*;
#(
    parameter int WORD_BITS       = 8,
    parameter int FIFO_ADDR_BITS  = 6,
    parameter int CHAR_GAP_CYCLES = 3 * UNIT_CYCLES,
    parameter int WORD_GAP_CYCLES = 7 * UNIT_CYCLES,
    parameter int TIMEOUT_CYCLES  = 200_000_000
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 clear_i,
    input  logic                 rx_done_i,
    input  logic [WORD_BITS-1:0] rx_data_i,
    input  logic                 morse_done_i,
    output logic [WORD_BITS-1:0] ascii_o,
    output logic                 morse_en_o,
    output logic                 busy_o,
    output logic                 fifo_empty_o,
    output logic                 fifo_full_o,
    output logic                 overflow_o,
    output logic                 timeout_o
);

    localparam int MAXC = max2(max2(CHAR_GAP_CYCLES, WORD_GAP_CYCLES), TIMEOUT_CYCLES);
    localparam int CW   = $clog2(MAXC) + 1;
    // a zero-length gap still spends one cycle in GAP
    localparam logic [CW-1:0] CHAR_LD = CW'((CHAR_GAP_CYCLES > 0) ? CHAR_GAP_CYCLES - 1 : 0);
    localparam logic [CW-1:0] WORD_LD = CW'((WORD_GAP_CYCLES > 0) ? WORD_GAP_CYCLES - 1 : 0);
    localparam logic [CW-1:0] TO_LD   = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t               state_q, state_d;
    logic [WORD_BITS-1:0] ascii_q, ascii_d, head;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 overflow_q;

    sync_fifo #(
        .WIDTH    (WORD_BITS),
        .ADDR_BITS(FIFO_ADDR_BITS)
    ) u_fifo (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clear_i  (clear_i),
        .wr_en_i  (rx_done_i),
        .wr_data_i(rx_data_i),
        .rd_en_i  (state_q == S_LOAD),
        .head_o   (head),
        .empty_o  (fifo_empty_o),
        .full_o   (fifo_full_o)
    );

    assign ascii_o    = ascii_q;
    assign morse_en_o = state_q == S_START;
    assign busy_o     = state_q != S_IDLE;
    assign overflow_o = overflow_q;

`ifdef MORSE_SCHED_TIMEOUT_EN
    logic timeout_q, timeout_d;
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    // next-state: one transition per clock, gap counter shared by all timed states
    always_comb begin
        state_d = state_q;
        ascii_d = ascii_q;
        cnt_d   = cnt_q;
`ifdef MORSE_SCHED_TIMEOUT_EN
        timeout_d = timeout_q;
`endif
        case (state_q)
            S_IDLE:  if (!fifo_empty_o) state_d = S_LOAD;
            S_LOAD: begin
                ascii_d = head;
                state_d = (head == ASCII_SPACE) ? S_GAP : S_START;
                cnt_d   = WORD_LD;
            end
            S_START: begin
                state_d = S_WAIT;
                cnt_d   = TO_LD;
            end
            S_WAIT: begin
                if (morse_done_i) begin
                    state_d = S_GAP;
                    cnt_d   = CHAR_LD;
                end
`ifdef MORSE_SCHED_TIMEOUT_EN
                else if (cnt_q == '0) begin
                    timeout_d = 1'b1;
                    state_d   = S_GAP;
                    cnt_d     = CHAR_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
`endif
            end
            S_GAP: begin
                state_d = (cnt_q == '0) ? S_IDLE : S_GAP;
                cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM registers; flush aborts the current character like reset
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            state_q <= S_IDLE;
            ascii_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ascii_q <= ascii_d;
            cnt_q   <= cnt_d;
        end
    end

    // sticky error flags survive a flush, only reset clears them
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            overflow_q <= 1'b0;
`ifdef MORSE_SCHED_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
        end else if (!clear_i) begin
            if (rx_done_i && fifo_full_o) overflow_q <= 1'b1;
`ifdef MORSE_SCHED_TIMEOUT_EN
            timeout_q <= timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_morse_scheduler.sv
// tb_morse_scheduler: directed checks of queueing, pacing, spaces, overflow, flush and reset
module tb_morse_scheduler;

    localparam int CG = 4;
    localparam int WG = 9;
    localparam int TO = 20;
    localparam int DLY = 10;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1, clear_i = 1'b0, rx_done_i = 1'b0, morse_done_i;
    logic [7:0] rx_data_i = '0, ascii_o;
    logic       morse_en_o, busy_o, fifo_empty_o, fifo_full_o, overflow_o, timeout_o;

    int n_tests = 0, n_fail = 0, cyc = 0;
    int en_ascii[$], en_cyc[$];
    int last_done = -1, fall_cyc = -1, b, c0, e0;
    logic busy_prev = 1'b0, auto_done = 1'b0, kick = 1'b0;

    morse_scheduler #(
        .WORD_BITS      (8),
        .FIFO_ADDR_BITS (2),
        .CHAR_GAP_CYCLES(CG),
        .WORD_GAP_CYCLES(WG),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .clear_i     (clear_i),
        .rx_done_i   (rx_done_i),
        .rx_data_i   (rx_data_i),
        .morse_done_i(morse_done_i),
        .ascii_o     (ascii_o),
        .morse_en_o  (morse_en_o),
        .busy_o      (busy_o),
        .fifo_empty_o(fifo_empty_o),
        .fifo_full_o (fifo_full_o),
        .overflow_o  (overflow_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (morse_en_o) begin
            en_ascii.push_back(int'(ascii_o));
            en_cyc.push_back(cyc);
        end
        if (morse_done_i) last_done = cyc;
        if (busy_prev && !busy_o) fall_cyc = cyc;
        busy_prev = busy_o;
    end

    initial begin
        morse_done_i = 1'b0;
        forever begin
            @(negedge clk);
            if (kick || (auto_done && morse_en_o)) begin
                repeat (DLY) @(posedge clk);
                #1 morse_done_i = 1'b1;
                @(posedge clk);
                #1 morse_done_i = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        rx_done_i = 1'b1;
        rx_data_i = d;
        tick();
        rx_done_i = 1'b0;
    endtask

    task automatic pulse_done();
        kick = 1'b1;
        tick();
        kick = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        reset_i = 1'b0;
        check("rst_empty", fifo_empty_o, 1);
        check("rst_full", fifo_full_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_en", morse_en_o, 0);
        check("rst_ascii", ascii_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_to", timeout_o, 0);

        auto_done = 1'b1;
        b = en_ascii.size();
        c0 = cyc;
        push(8'h53);
        check("s_nonempty", fifo_empty_o, 0);
        check("s_idle_c1", busy_o, 0);
        repeat (40) tick();
        check("s_count", en_ascii.size() - b, 1);
        check("s_ascii", en_ascii[b], 32'h53);
        check("s_en_cyc", en_cyc[b] - c0, 3);
        check("s_done_cyc", last_done - en_cyc[b], DLY);
        check("s_busy_fall", fall_cyc - last_done, CG + 1);

        b = en_ascii.size();
        push(8'h53);
        push(8'h4F);
        push(8'h53);
        repeat (60) tick();
        check("sos_count", en_ascii.size() - b, 3);
        check("sos_a0", en_ascii[b], 32'h53);
        check("sos_a1", en_ascii[b+1], 32'h4F);
        check("sos_a2", en_ascii[b+2], 32'h53);
        check("sos_gap01", en_cyc[b+1] - en_cyc[b], DLY + CG + 3);
        check("sos_gap12", en_cyc[b+2] - en_cyc[b+1], DLY + CG + 3);

        b = en_ascii.size();
        push(8'h41);
        push(8'h20);
        push(8'h42);
        repeat (50) tick();
        check("sp_count", en_ascii.size() - b, 2);
        check("sp_a0", en_ascii[b], 32'h41);
        check("sp_a1", en_ascii[b+1], 32'h42);
        check("sp_gap", en_cyc[b+1] - en_cyc[b], DLY + CG + 3 + WG + 2);

        auto_done = 1'b0;
        b = en_ascii.size();
        for (int i = 0; i < 6; i++) push(8'h31 + 8'(i));
        check("ov_full", fifo_full_o, 1);
        check("ov_flag", overflow_o, 1);
        check("ov_inflight", en_ascii.size() - b, 1);
        check("ov_first", en_ascii[b], 32'h31);
        auto_done = 1'b1;
        pulse_done();
        repeat (120) tick();
        check("ov_count", en_ascii.size() - b, 5);
        for (int i = 1; i < 5; i++) check($sformatf("ov_order%0d", i), en_ascii[b+i], 32'h31 + i);
        check("ov_empty", fifo_empty_o, 1);
        check("ov_notfull", fifo_full_o, 0);
        check("ov_sticky", overflow_o, 1);

        auto_done = 1'b0;
        b = en_ascii.size();
        push(8'h45);
        push(8'h46);
        repeat (3) tick();
        check("clr_inwait", busy_o, 1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("clr_idle", busy_o, 0);
        check("clr_empty", fifo_empty_o, 1);
        check("clr_ascii", ascii_o, 0);
        check("clr_ovf_kept", overflow_o, 1);
        pulse_done();
        repeat (30) tick();
        check("clr_count", en_ascii.size() - b, 1);
        check("clr_still_idle", busy_o, 0);

        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("rst2_ovf", overflow_o, 0);
        check("rst2_empty", fifo_empty_o, 1);

`ifdef MORSE_SCHED_TIMEOUT_EN
        b = en_ascii.size();
        c0 = cyc;
        push(8'h54);
        push(8'h55);
        e0 = c0 + 3;
        repeat (e0 + TO - cyc) tick();
        check("to_before", timeout_o, 0);
        tick();
        check("to_after", timeout_o, 1);
        repeat (20) tick();
        check("to_count", en_ascii.size() - b, 2);
        check("to_next", en_ascii[b+1], 32'h55);
        check("to_next_cyc", en_cyc[b+1] - e0, TO + CG + 3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
